alarm_siren_ctrl: RTL
=====================

// Module: alarm_siren_ctrl
// PURPOSE
//  Sequential stage directly downstream of the combinational alarm-decode logic.
//  - Consumes its single alarm-condition bit A and arms/disarms the system.
//  - Applies an entry delay, then drives a pulsed siren for a bounded time.
//  - Latches a "tripped" memory bit until the user acknowledges it while disarmed.
// PARAMETERS
//  ENTRY_DLY  8   cycles from entering ENTRY to entering ALARM (>=1)
//  SIREN_LEN  64  max cycles spent in ALARM before auto-silence (>=1)
//  BEEP_HALF  4   siren half-period in cycles (>=1)
//  CNT_W      8   counter width; must satisfy 2^CNT_W > max(ENTRY_DLY,SIREN_LEN,BEEP_HALF)
// PORTS
//  Clk        in   1  system clock, rising edge
//  Reset_n    in   1  asynchronous, active-low reset
//  A          in   1  alarm condition from alarm decode, synchronous to Clk
//  Arm        in   1  level; 1 = system armed, 0 = disarm request
//  Ack        in   1  one-cycle pulse: silence siren / clear Tripped
//  Siren      out  1  pulsed siren drive, registered
//  Pending    out  1  1 while in ENTRY (entry-delay warning)
//  Armed_led  out  1  1 in every state except DISARMED
//  Tripped    out  1  latched: ALARM has been entered since last clear
//  State      out  3  current state code, for debug/display
// BEHAVIOUR
//  - Reset (Reset_n=0, async): State=DISARMED; Siren, Pending, Armed_led, Tripped = 0;
//    all counters = 0. Takes effect immediately, mid-operation included.
//  - States: DISARMED=0, ARMED=1, ENTRY=2, ALARM=3, SILENCED=4; codes 5-7 go to DISARMED.
//  - All inputs are sampled on the rising edge. All outputs are registered or decoded
//    from the State register only (Moore); no combinational path from input to output.
//  - DISARMED: Arm=1 -> ARMED. Ack=1 -> Tripped<=0. A is ignored.
//  - ARMED: Arm=0 -> DISARMED. Otherwise A=1 -> ENTRY, entry_cnt<=0.
//  - ENTRY:
//      - Arm=0 -> DISARMED (highest priority).
//      - Otherwise entry_cnt increments every cycle regardless of A
//        (the event is already latched).
//      - When entry_cnt==ENTRY_DLY-1 -> ALARM. State is ENTRY for exactly ENTRY_DLY cycles.
//  - ALARM entry: on the same edge, Tripped<=1, Siren<=1, beep_cnt<=0, alarm_cnt<=0.
//  - ALARM, per cycle:
//      - beep_cnt increments; at beep_cnt==BEEP_HALF-1, Siren toggles and beep_cnt<=0.
//        Result: square wave, BEEP_HALF cycles high, then BEEP_HALF low.
//      - alarm_cnt increments every cycle.
//  - ALARM exit priority: Arm=0 -> DISARMED > Ack=1 -> SILENCED >
//    alarm_cnt==SIREN_LEN-1 -> SILENCED. State is ALARM for at most SIREN_LEN cycles.
//  - Any exit from ALARM: Siren<=0 on that same edge.
//  - SILENCED: Siren=0. Arm=0 -> DISARMED. Else A=0 -> ARMED. Else stay.
//    No re-trigger while A stays high.
//  - Tripped: set only on entering ALARM; cleared only by Ack in DISARMED.
//    Disarming does not clear it.
//  - Ack outside ALARM/DISARMED has no effect.
//  - Arm=0 together with Ack in ALARM -> DISARMED; Tripped remains 1.
//  - Counters never wrap: each is reloaded on state entry and bounded by its compare.
// TESTING
//  1. Arm=1; A=1 for 1 cycle -> Pending=1 for 8 cycles; then Siren 1,1,1,1,0,0,0,0,...;
//     Tripped=1; after 64 ALARM cycles -> SILENCED, Siren=0; A=0 -> ARMED.
//  2. Arm=1, A=1; drop Arm on ENTRY cycle 5 -> DISARMED next edge, Siren never 1,
//     Tripped=0.
//  3. In ALARM, Ack on ALARM cycle 10 -> SILENCED next edge, Siren=0.
//     Hold A=1 for 20 cycles -> stays SILENCED. A=0 -> ARMED. Tripped stays 1.
//  4. In ALARM, Arm=0 and Ack same cycle -> DISARMED, Tripped=1.
//     Ack in DISARMED -> Tripped=0.
//  5. Arm=0, sweep A high for 10 cycles -> State stays 0, all outputs 0.
//  6. Assert Reset_n=0 mid-ALARM between clock edges -> all outputs 0 immediately.
//     Release -> DISARMED.

Source files
------------

// File: rtl/alarm_siren_ctrl.sv
// Alarm siren controller: arm/disarm, entry delay, bounded pulsed siren and a
// latched tripped flag. Moore machine; every output comes from a register.
module alarm_siren_ctrl #(
  parameter int unsigned ENTRY_DLY = 8,
  parameter int unsigned SIREN_LEN = 64,
  parameter int unsigned BEEP_HALF = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       A,
  input  logic       Arm,
  input  logic       Ack,
  output logic       Siren,
  output logic       Pending,
  output logic       Armed_led,
  output logic       Tripped,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_ARMED    = 3'd1,
    S_ENTRY    = 3'd2,
    S_ALARM    = 3'd3,
    S_SILENCED = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] ENTRY_LAST = CNT_W'(ENTRY_DLY - 1);
  localparam logic [CNT_W-1:0] SIREN_LAST = CNT_W'(SIREN_LEN - 1);
  localparam logic [CNT_W-1:0] BEEP_LAST  = CNT_W'(BEEP_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] entry_cnt_q, entry_cnt_d;
  logic [CNT_W-1:0] beep_cnt_q, beep_cnt_d;
  logic [CNT_W-1:0] alarm_cnt_q, alarm_cnt_d;
  logic             siren_q, siren_d;
  logic             tripped_q, tripped_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_DISARMED;
      entry_cnt_q <= '0;
      beep_cnt_q  <= '0;
      alarm_cnt_q <= '0;
      siren_q     <= 1'b0;
      tripped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_cnt_q <= entry_cnt_d;
      beep_cnt_q  <= beep_cnt_d;
      alarm_cnt_q <= alarm_cnt_d;
      siren_q     <= siren_d;
      tripped_q   <= tripped_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    entry_cnt_d = entry_cnt_q;
    beep_cnt_d  = beep_cnt_q;
    alarm_cnt_d = alarm_cnt_q;
    siren_d     = siren_q;
    tripped_d   = tripped_q;
    case (state_q)
      S_DISARMED: begin
        siren_d = 1'b0;
        if (Ack) tripped_d = 1'b0;
        if (Arm) state_d = S_ARMED;
      end
      S_ARMED: begin
        siren_d = 1'b0;
        if (!Arm) begin
          state_d = S_DISARMED;
        end else if (A) begin
          state_d     = S_ENTRY;
          entry_cnt_d = '0;
        end
      end
      S_ENTRY: begin
        // A is not looked at here: the triggering event is already latched.
        if (!Arm) begin
          state_d = S_DISARMED;
        end else if (entry_cnt_q == ENTRY_LAST) begin
          state_d     = S_ALARM;
          tripped_d   = 1'b1;
          siren_d     = 1'b1;
          beep_cnt_d  = '0;
          alarm_cnt_d = '0;
        end else begin
          entry_cnt_d = entry_cnt_q + CNT_ONE;
        end
      end
      S_ALARM: begin
        if (!Arm) begin
          state_d = S_DISARMED;
          siren_d = 1'b0;
        end else if (Ack || (alarm_cnt_q == SIREN_LAST)) begin
          state_d = S_SILENCED;
          siren_d = 1'b0;
        end else begin
          alarm_cnt_d = alarm_cnt_q + CNT_ONE;
          if (beep_cnt_q == BEEP_LAST) begin
            siren_d    = ~siren_q;
            beep_cnt_d = '0;
          end else begin
            beep_cnt_d = beep_cnt_q + CNT_ONE;
          end
        end
      end
      S_SILENCED: begin
        // Only a return of A to 0 re-arms, so a stuck sensor cannot re-trigger.
        siren_d = 1'b0;
        if (!Arm)   state_d = S_DISARMED;
        else if (!A) state_d = S_ARMED;
      end
      default: begin
        state_d = S_DISARMED;
        siren_d = 1'b0;
      end
    endcase
  end

  assign State     = state_q;
  assign Pending   = (state_q == S_ENTRY);
  assign Armed_led = (state_q != S_DISARMED);
  assign Siren     = siren_q;
  assign Tripped   = tripped_q;

endmodule
